// File: rtl/fir_tdm_mac.sv
// fir_tdm_mac: time-division-multiplexed unsigned FIR filter.
//
// A TAPS-deep sample delay line and a loadable TAPS-entry coefficient bank feed
// MULTS shared multipliers. Each output is built over PHASES = TAPS/MULTS cycles,
// MULTS taps per cycle, into an ACC_W-bit accumulator that cannot overflow.
// valid/ready handshakes on both the sample input and the result output.
//
// Optional feature (macro FIR_SAT_EN):
//   defined   - final sum >= 2^OUT_W clamps out_data to all ones and sets out_sat
//   undefined - out_data is the sum truncated to OUT_W bits, out_sat tied 0
//
// Ports:
//   clk, rst_n           clock (rising edge), asynchronous active-low reset
//   clear                synchronous flush of delay line, accumulator and FSM
//   coef_we/addr/data    coefficient write, accepted only while coef_ready=1
//   coef_ready           FSM is idle and a coefficient write is accepted
//   in_valid/ready/data  sample input handshake
//   out_valid/ready      result output handshake
//   out_data, out_sat    filter result and saturation flag

module fir_tdm_mac #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned COEF_W = 8,
    parameter int unsigned TAPS   = 4,
    parameter int unsigned MULTS  = 2,
    parameter int unsigned OUT_W  = 18
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic                                   clear,
    input  logic                                   coef_we,
    input  logic [((TAPS > 1) ? $clog2(TAPS) : 1)-1:0] coef_addr,
    input  logic [COEF_W-1:0]                      coef_data,
    output logic                                   coef_ready,
    input  logic                                   in_valid,
    output logic                                   in_ready,
    input  logic [DATA_W-1:0]                      in_data,
    output logic                                   out_valid,
    input  logic                                   out_ready,
    output logic [OUT_W-1:0]                       out_data,
    output logic                                   out_sat
);

    localparam int unsigned PHASES = TAPS / MULTS;
    localparam int unsigned ACC_W  = DATA_W + COEF_W + $clog2(TAPS);
    localparam int unsigned PROD_W = DATA_W + COEF_W;
    localparam int unsigned PH_W   = (PHASES > 1) ? $clog2(PHASES) : 1;
    localparam int unsigned AD_W   = (TAPS > 1) ? $clog2(TAPS) : 1;

    if (TAPS < 1 || MULTS < 1 || (TAPS % MULTS) != 0) begin : g_bad_taps
        $error("fir_tdm_mac: TAPS must be >= 1 and a multiple of MULTS");
    end
    if (OUT_W > ACC_W) begin : g_bad_out_w
        $error("fir_tdm_mac: OUT_W must not exceed ACC_W");
    end

    typedef enum logic [1:0] {StIdle, StMac, StHold} state_e;

    state_e              state_q, state_d;
    logic [DATA_W-1:0]   x_q [TAPS];
    logic [COEF_W-1:0]   c_q [TAPS];
    logic [ACC_W-1:0]    acc_q;
    logic [PH_W-1:0]     phase_q;
    logic [OUT_W-1:0]    out_data_q;
    logic                out_sat_q;

    logic                last_phase;
    logic                addr_ok;
    logic [DATA_W-1:0]   mul_x [MULTS];
    logic [COEF_W-1:0]   mul_c [MULTS];
    logic [ACC_W-1:0]    psum;
    logic [ACC_W-1:0]    final_sum;
    logic [OUT_W-1:0]    res_d;
    logic                sat_d;

    assign last_phase = (phase_q == PH_W'(PHASES - 1));
    // Only matters when TAPS is not a power of two.
    assign addr_ok    = (32'(coef_addr) < TAPS);

    // FSM next state and handshake outputs; clear overrides everything.
    always_comb begin
        state_d    = state_q;
        in_ready   = 1'b0;
        coef_ready = 1'b0;
        unique case (state_q)
            StIdle: begin
                in_ready   = !clear;
                coef_ready = !clear;
                if (in_valid) state_d = StMac;
            end
            StMac: begin
                if (last_phase) state_d = StHold;
            end
            StHold: begin
                if (out_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
        if (clear) state_d = StIdle;
    end

    // Operand muxes: multiplier j serves tap phase*MULTS+j in the current phase.
    always_comb begin
        psum = '0;
        for (int j = 0; j < MULTS; j++) begin
            mul_x[j] = '0;
            mul_c[j] = '0;
            for (int p = 0; p < PHASES; p++) begin
                if (phase_q == PH_W'(p)) begin
                    mul_x[j] = x_q[p * MULTS + j];
                    mul_c[j] = c_q[p * MULTS + j];
                end
            end
            psum = psum + ACC_W'(PROD_W'(mul_x[j]) * PROD_W'(mul_c[j]));
        end
    end

    assign final_sum = acc_q + psum;

`ifdef FIR_SAT_EN
    always_comb begin
        sat_d = ((final_sum >> OUT_W) != '0);
        res_d = sat_d ? {OUT_W{1'b1}} : final_sum[OUT_W-1:0];
    end
`else
    always_comb begin
        sat_d = 1'b0;
        res_d = final_sum[OUT_W-1:0];
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            acc_q      <= '0;
            phase_q    <= '0;
            out_data_q <= '0;
            out_sat_q  <= 1'b0;
            for (int k = 0; k < TAPS; k++) begin
                x_q[k] <= '0;
                c_q[k] <= '0;
            end
        end else if (clear) begin
            state_q <= state_d;
            acc_q   <= '0;
            phase_q <= '0;
            for (int k = 0; k < TAPS; k++) x_q[k] <= '0;
        end else begin
            state_q <= state_d;
            // Written before the MAC phases begin, so a write on the accept
            // edge is seen by that sample's computation.
            if (coef_we && coef_ready && addr_ok) c_q[coef_addr] <= coef_data;
            if (in_valid && in_ready) begin
                x_q[0] <= in_data;
                for (int k = 1; k < TAPS; k++) x_q[k] <= x_q[k-1];
                acc_q   <= '0;
                phase_q <= '0;
            end
            if (state_q == StMac) begin
                acc_q   <= final_sum;
                phase_q <= phase_q + PH_W'(1);
                if (last_phase) begin
                    out_data_q <= res_d;
                    out_sat_q  <= sat_d;
                end
            end
        end
    end

    assign out_valid = (state_q == StHold);
    assign out_data  = out_data_q;
    assign out_sat   = out_sat_q;

endmodule
